// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, oversampling tick and received-byte outputs of the UART receiver
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_rx;
  logic                 i_tick;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_rx_done;
  logic                 o_frame_error;
  logic                 o_busy;
  modport master (output i_rx, i_tick, input o_data, o_rx_done, o_frame_error, o_busy);
  modport slave  (input i_rx, i_tick, output o_data, o_rx_done, o_frame_error, o_busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 receiver with one-cycle done strobe and framing-error flag
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int NUM_TICKS  = 16,
  parameter int STOP_TICKS = 16
) (
  input logic     i_clock,
  input logic     i_reset,
  uart_rx_if.slave bus
);
  localparam int TW = $clog2(NUM_TICKS);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_MID  = TW'(NUM_TICKS / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(NUM_TICKS - 1);
  localparam logic [TW-1:0] T_STOP = TW'(STOP_TICKS - 1);
  localparam logic [BW-1:0] B_END  = BW'(DATA_BITS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_m, rx_s;
  // Synchronizer flops reset high so a reset never looks like a start edge
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) {rx_s, rx_m} <= 2'b11;
    else         {rx_s, rx_m} <= {rx_m, bus.i_rx};
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      state             <= IDLE;
      tick_cnt          <= '0;
      bit_cnt           <= '0;
      shreg             <= '0;
      bus.o_data        <= '0;
      bus.o_rx_done     <= 1'b0;
      bus.o_frame_error <= 1'b0;
      bus.o_busy        <= 1'b0;
    end else begin
      bus.o_rx_done <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state      <= START;
          tick_cnt   <= '0;
          bus.o_busy <= 1'b1;
        end
        START: if (bus.i_tick) begin
          if (tick_cnt != T_MID) tick_cnt <= tick_cnt + 1'b1;
          else if (!rx_s) begin
            state    <= DATA;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end else begin
            state      <= IDLE;
            bus.o_busy <= 1'b0;
          end
        end
        // LSB arrives first, so shifting in at the MSB leaves the byte aligned
        DATA: if (bus.i_tick) begin
          if (tick_cnt != T_END) tick_cnt <= tick_cnt + 1'b1;
          else begin
            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
            tick_cnt <= '0;
            if (bit_cnt == B_END) state <= STOP;
            else bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: if (bus.i_tick) begin
          if (tick_cnt != T_STOP) tick_cnt <= tick_cnt + 1'b1;
          else begin
            bus.o_data        <= shreg;
            bus.o_frame_error <= ~rx_s;
            bus.o_rx_done     <= 1'b1;
            bus.o_busy        <= 1'b0;
            state             <= IDLE;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame bench for uart_rx against a frame-level byte/flag model
`timescale 1ns/1ps
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_rx_if #(.DATA_BITS(8)) bus ();
  uart_rx #(.DATA_BITS(8), .NUM_TICKS(16), .STOP_TICKS(16)) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );
  int   errors = 0;
  int   checks = 0;
  int   per    = 163;
  int   tcnt   = 0;
  logic tick_en = 1'b0;
  logic [7:0] sd [$];
  logic       sf [$];
  time        st [$];
  time  rise_t = 0, fall_t = 0, start_t = 0;
  int   dbl = 0;
  logic prev_done = 1'b0, prev_busy = 1'b0;
  // Free-running tick generator, driven on the falling edge to stay clear of the DUT's sampling edge
  initial begin
    bus.i_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en && tcnt >= per - 1) begin
        bus.i_tick = 1'b1;
        tcnt = 0;
      end else begin
        bus.i_tick = 1'b0;
        if (tick_en) tcnt++;
      end
    end
  end
  always @(negedge clk) begin
    if (bus.o_rx_done) begin
      sd.push_back(bus.o_data);
      sf.push_back(bus.o_frame_error);
      st.push_back($time);
    end
    if (bus.o_rx_done && prev_done) dbl++;
    if (bus.o_busy && !prev_busy) rise_t = $time;
    if (!bus.o_busy && prev_busy) fall_t = $time;
    prev_done = bus.o_rx_done;
    prev_busy = bus.o_busy;
  end
  task automatic wait_tick();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!bus.i_tick && n < 2000);
    if (!bus.i_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no i_tick after %0d clocks, required one within 2000", n);
    end
  endtask
  // Line level for tick k of a 160-tick frame is bit k/16 of {stop, data, start}
  task automatic drive(input logic [9:0] fr, input int from, input int to);
    for (int k = from; k < to; k++) begin
      @(negedge clk);
      bus.i_rx = fr[k/16];
      if (k == 0) start_t = $time;
      wait_tick();
    end
  endtask
  task automatic send(input logic [7:0] d, input logic stop);
    wait_tick();
    drive({stop, d, 1'b0}, 0, stop ? 160 : 153);
    if (!stop) begin
      @(negedge clk);
      bus.i_rx = 1'b1;
      repeat (12) wait_tick();
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.i_rx = 1'b1;
    tick_en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.o_data, bus.o_rx_done, bus.o_frame_error, bus.o_busy} !== 11'h0)
      begin errors++; $display("FAIL reset_outputs: got %h, required 0", {bus.o_data, bus.o_rx_done, bus.o_frame_error, bus.o_busy}); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_rx_done !== 1'b0)
      begin errors++; $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", bus.o_busy, bus.o_rx_done); end
  endtask
  task automatic test_basic();
    int n0 = sd.size();
    per = 163;
    send(8'hA5, 1'b1);
    @(negedge clk);
    checks++;
    if (sd.size() !== n0 + 1) begin errors++; $display("FAIL basic_count: got %0d strobes, required 1", sd.size() - n0); end
    if (sd.size() > n0) begin
      checks++;
      if (sd[n0] !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h, required a5", sd[n0]); end
      checks++;
      if (sf[n0] !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b, required 0", sf[n0]); end
      checks++;
      if (fall_t !== st[n0]) begin errors++; $display("FAIL basic_busy_fall: got %0t, required %0t", fall_t, st[n0]); end
    end
    checks++;
    if (rise_t - start_t !== 30) begin errors++; $display("FAIL basic_busy_rise: got %0t after edge, required 30", rise_t - start_t); end
  endtask
  task automatic test_glitch();
    int n0 = sd.size();
    per = 5;
    wait_tick();
    drive(10'h000, 0, 3);
    @(negedge clk);
    bus.i_rx = 1'b1;
    repeat (4) wait_tick();
    #1;
    checks++;
    if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_t7: got %b, required 1", bus.o_busy); end
    wait_tick();
    #1;
    checks++;
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_t8: got %b, required 0", bus.o_busy); end
    repeat (20) wait_tick();
    checks++;
    if (sd.size() !== n0 || bus.o_data !== 8'hA5)
      begin errors++; $display("FAIL glitch_no_strobe: strobes=%0d data=%h, required 0 a5", sd.size() - n0, bus.o_data); end
  endtask
  task automatic test_framing();
    int n0 = sd.size();
    wait_tick();
    drive({1'b0, 8'h3C, 1'b0}, 0, 153);
    #1;
    checks++;
    if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL ferr_restart: busy=%b, required 1", bus.o_busy); end
    @(negedge clk);
    bus.i_rx = 1'b1;
    repeat (12) wait_tick();
    checks++;
    if (sd.size() !== n0 + 1) begin errors++; $display("FAIL ferr_count: got %0d strobes, required 1", sd.size() - n0); end
    else begin
      checks++;
      if ({sd[n0], sf[n0]} !== {8'h3C, 1'b1}) begin errors++; $display("FAIL ferr_frame: got %h/%b, required 3c/1", sd[n0], sf[n0]); end
    end
    send(8'h11, 1'b1);
    checks++;
    if (sd.size() !== n0 + 2) begin errors++; $display("FAIL ferr_next_count: got %0d strobes, required 2", sd.size() - n0); end
    else begin
      checks++;
      if ({sd[n0+1], sf[n0+1]} !== {8'h11, 1'b0}) begin errors++; $display("FAIL ferr_clear: got %h/%b, required 11/0", sd[n0+1], sf[n0+1]); end
    end
  endtask
  task automatic test_back_to_back();
    int n0 = sd.size();
    wait_tick();
    drive({1'b1, 8'h00, 1'b0}, 0, 160);
    drive({1'b1, 8'hFF, 1'b0}, 0, 160);
    checks++;
    if (sd.size() !== n0 + 2) begin errors++; $display("FAIL b2b_count: got %0d strobes, required 2", sd.size() - n0); end
    else begin
      checks++;
      if ({sd[n0], sf[n0], sd[n0+1], sf[n0+1]} !== {8'h00, 1'b0, 8'hFF, 1'b0})
        begin errors++; $display("FAIL b2b_data: got %h/%b %h/%b, required 00/0 ff/0", sd[n0], sf[n0], sd[n0+1], sf[n0+1]); end
      checks++;
      if (st[n0+1] - st[n0] !== time'(160 * per * 10))
        begin errors++; $display("FAIL b2b_spacing: got %0t, required %0d", st[n0+1] - st[n0], 160 * per * 10); end
    end
  endtask
  task automatic test_reset_mid();
    int n0 = sd.size();
    wait_tick();
    drive({1'b1, 8'h5A, 1'b0}, 0, 88);
    #2;
    checks++;
    if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b, required 1", bus.o_busy); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.o_data, bus.o_rx_done, bus.o_frame_error, bus.o_busy} !== 11'h0)
      begin errors++; $display("FAIL rmid_async_clear: got %h, required 0", {bus.o_data, bus.o_rx_done, bus.o_frame_error, bus.o_busy}); end
    @(negedge clk);
    bus.i_rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) wait_tick();
    checks++;
    if (sd.size() !== n0) begin errors++; $display("FAIL rmid_no_strobe: got %0d strobes, required 0", sd.size() - n0); end
    send(8'h5A, 1'b1);
    checks++;
    if (sd.size() !== n0 + 1) begin errors++; $display("FAIL rmid_count: got %0d strobes, required 1", sd.size() - n0); end
    else begin
      checks++;
      if ({sd[n0], sf[n0]} !== {8'h5A, 1'b0}) begin errors++; $display("FAIL rmid_frame: got %h/%b, required 5a/0", sd[n0], sf[n0]); end
    end
  endtask
  task automatic test_pause();
    int n0 = sd.size();
    int bad = 0;
    logic [9:0] fr;
    fr = {1'b1, 8'hC3, 1'b0};
    wait_tick();
    drive(fr, 0, 72);
    tick_en = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.o_busy !== 1'b1 || sd.size() != n0 || bus.o_data !== 8'h5A) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL pause_frozen: %0d cycles changed, required 0", bad); end
    tick_en = 1'b1;
    drive(fr, 72, 160);
    checks++;
    if (sd.size() !== n0 + 1) begin errors++; $display("FAIL pause_count: got %0d strobes, required 1", sd.size() - n0); end
    else begin
      checks++;
      if ({sd[n0], sf[n0]} !== {8'hC3, 1'b0}) begin errors++; $display("FAIL pause_frame: got %h/%b, required c3/0", sd[n0], sf[n0]); end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int n0 = sd.size();
      logic [7:0] d;
      logic stop;
      logic [9:0] fr;
      per  = $urandom_range(4, 8);
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      fr   = {stop, d, 1'b0};
      send(d, stop);
      checks++;
      if (sd.size() !== n0 + 1) begin errors++; $display("FAIL rand%0d_count: got %0d strobes, required 1", i, sd.size() - n0); end
      else begin
        checks++;
        if ({sd[n0], sf[n0]} !== {fr[8:1], ~fr[9]})
          begin errors++; $display("FAIL rand%0d_frame: got %h/%b, required %h/%b", i, sd[n0], sf[n0], fr[8:1], ~fr[9]); end
      end
    end
  endtask
  task automatic test_strobe_width();
    checks++;
    if (dbl != 0) begin errors++; $display("FAIL strobe_width: %0d multi-cycle strobes, required 0", dbl); end
  endtask
  initial begin
    bus.i_rx = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid();
    test_pause();
    test_random();
    test_strobe_width();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
